// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//   Plays a programmable sequence of configuration words from one of NBANK
//   pattern banks onto cfg_out. A run plays steps 0..seq_len of the chosen
//   bank, (repeat_cnt+1) times back to back. The MSB of cfg_out is gated low
//   for early steps, and flag_adc pulses on a chosen step. Banks are filled
//   through a byte-wide write port in PROG mode, MSB byte first.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, abort        run control (start honoured in IDLE only)
//   bank_sel, seq_len,  run configuration, latched when the run starts
//   repeat_cnt,
//   gate_start,
//   flag_step
//   wr_en, wr_stb,      programming: session request, byte strobe,
//   wr_bank, wr_data    target bank (latched on entry) and data byte
//   cfg_out             registered configuration word (IDLE_WORD when idle)
//   flag_adc            registered 1-cycle pulse on the flag step
//   busy                high while running
//   done                1-cycle pulse after a run completes normally
//   wr_full             high once the bank has been filled this session
module pattern_sequencer #(
  parameter int                WORD_W    = 16,
  parameter int                ADDR_W    = 6,
  parameter int                NBANK     = 4,
  parameter int                BANK_W    = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD = 16'h1404
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [ADDR_W-1:0] seq_len,
  input  logic [7:0]        repeat_cnt,
  input  logic [ADDR_W-1:0] gate_start,
  input  logic [ADDR_W-1:0] flag_step,
  input  logic              wr_en,
  input  logic              wr_stb,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [7:0]        wr_data,
  output logic [WORD_W-1:0] cfg_out,
  output logic              flag_adc,
  output logic              busy,
  output logic              done,
  output logic              wr_full
);

  localparam int BYTES  = WORD_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  // Assembler holds only the bytes still waiting for the final one.
  localparam int ASM_W  = (BYTES > 1) ? (WORD_W - 8) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PROG = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [7:0]          pass_q, pass_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [7:0]          rep_q, rep_d;
  logic [ADDR_W-1:0]   gate_q, gate_d;
  logic [ADDR_W-1:0]   fstep_q, fstep_d;
  logic [BANK_W-1:0]   wbank_q, wbank_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [ASM_W-1:0]    asm_q, asm_d;
  logic                wr_full_q, wr_full_d;
  logic [WORD_W-1:0]   cfg_out_q, cfg_out_d;
  logic                flag_adc_q, flag_adc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  // Set on the edge that ends a normal run; done follows one cycle later so
  // that it lines up with cfg_out returning to IDLE_WORD.
  logic                fin_q, fin_d;

  logic [WORD_W-1:0]   mem_q [NBANK][DEPTH];
  logic                mem_we;
  logic [BANK_W-1:0]   mem_wbank;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WORD_W-1:0]   mem_wdata;

  logic [WORD_W-1:0]   rd_word;
  logic [WORD_W-1:0]   gated_word;
  logic [WORD_W-1:0]   asm_word;
  logic [ASM_W-1:0]    asm_keep;

  // Word formed by the pending bytes plus the incoming byte, and the
  // portion of it kept in the assembler for the next strobe.
  if (BYTES > 1) begin : g_multi_byte
    assign asm_word = {asm_q, wr_data};
    assign asm_keep = asm_word[ASM_W-1:0];
  end else begin : g_single_byte
    assign asm_word = wr_data;
    assign asm_keep = asm_q;
  end

  assign rd_word    = mem_q[bank_q][step_q];
  // MSB is forced low for steps below gate_start; gate_start=0 never gates.
  assign gated_word = {rd_word[WORD_W-1] & (step_q >= gate_q), rd_word[WORD_W-2:0]};

  // Next-state, counter and output computation.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    pass_d     = pass_q;
    bank_d     = bank_q;
    len_d      = len_q;
    rep_d      = rep_q;
    gate_d     = gate_q;
    fstep_d    = fstep_q;
    wbank_d    = wbank_q;
    wptr_d     = wptr_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    wr_full_d  = wr_full_q;
    cfg_out_d  = IDLE_WORD;
    flag_adc_d = 1'b0;
    fin_d      = 1'b0;
    done_d     = fin_q;
    mem_we     = 1'b0;
    mem_wbank  = wbank_q;
    mem_waddr  = wptr_q;
    mem_wdata  = asm_word;

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          state_d   = ST_PROG;
          wbank_d   = wr_bank;
          wptr_d    = {ADDR_W{1'b0}};
          bcnt_d    = {BCNT_W{1'b0}};
          asm_d     = {ASM_W{1'b0}};
          wr_full_d = 1'b0;
        end else if (start) begin
          state_d = ST_RUN;
          bank_d  = bank_sel;
          len_d   = seq_len;
          rep_d   = repeat_cnt;
          gate_d  = gate_start;
          fstep_d = flag_step;
          step_d  = {ADDR_W{1'b0}};
          pass_d  = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // The word for the current step is registered even on the abort
        // edge; IDLE_WORD appears the cycle after.
        cfg_out_d = gated_word;
        if (abort) begin
          state_d    = ST_IDLE;
          flag_adc_d = 1'b0;
          step_d     = {ADDR_W{1'b0}};
          pass_d     = 8'd0;
        end else begin
          flag_adc_d = (step_q == fstep_q);
          if (step_q == len_q) begin
            if (pass_q < rep_q) begin
              step_d = {ADDR_W{1'b0}};
              pass_d = pass_q + 8'd1;
            end else begin
              state_d = ST_IDLE;
              fin_d   = 1'b1;
              step_d  = {ADDR_W{1'b0}};
              pass_d  = 8'd0;
            end
          end else begin
            step_d = step_q + ADDR_W'(1);
          end
        end
      end

      ST_PROG: begin
        if (!wr_en) begin
          // Leaving PROG drops any partially assembled word.
          state_d   = ST_IDLE;
          wptr_d    = {ADDR_W{1'b0}};
          bcnt_d    = {BCNT_W{1'b0}};
          asm_d     = {ASM_W{1'b0}};
          wr_full_d = 1'b0;
        end else if (wr_stb && !wr_full_q) begin
          if (bcnt_q == BCNT_W'(BYTES - 1)) begin
            mem_we = 1'b1;
            bcnt_d = {BCNT_W{1'b0}};
            asm_d  = {ASM_W{1'b0}};
            wptr_d = wptr_q + ADDR_W'(1);
            if (wptr_q == ADDR_W'(DEPTH - 1)) begin
              // Pointer wraps to 0 but wr_full blocks further writes.
              wr_full_d = 1'b1;
            end else begin
              wr_full_d = 1'b0;
            end
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            asm_d  = asm_keep;
          end
        end else begin
          state_d = ST_PROG;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= {ADDR_W{1'b0}};
      pass_q     <= 8'd0;
      bank_q     <= {BANK_W{1'b0}};
      len_q      <= {ADDR_W{1'b0}};
      rep_q      <= 8'd0;
      gate_q     <= {ADDR_W{1'b0}};
      fstep_q    <= {ADDR_W{1'b0}};
      wbank_q    <= {BANK_W{1'b0}};
      wptr_q     <= {ADDR_W{1'b0}};
      bcnt_q     <= {BCNT_W{1'b0}};
      asm_q      <= {ASM_W{1'b0}};
      wr_full_q  <= 1'b0;
      cfg_out_q  <= IDLE_WORD;
      flag_adc_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pass_q     <= pass_d;
      bank_q     <= bank_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      gate_q     <= gate_d;
      fstep_q    <= fstep_d;
      wbank_q    <= wbank_d;
      wptr_q     <= wptr_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      wr_full_q  <= wr_full_d;
      cfg_out_q  <= cfg_out_d;
      flag_adc_q <= flag_adc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fin_q      <= fin_d;
    end
  end

  // Pattern bank write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wbank][mem_waddr] <= mem_wdata;
    end
  end

  assign cfg_out  = cfg_out_q;
  assign flag_adc = flag_adc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_full  = wr_full_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

  localparam logic [15:0] IDLE_W = 16'h1404;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [1:0]  bank_sel;
  logic [5:0]  seq_len;
  logic [7:0]  repeat_cnt;
  logic [5:0]  gate_start;
  logic [5:0]  flag_step;
  logic        wr_en, wr_stb;
  logic [1:0]  wr_bank;
  logic [7:0]  wr_data;
  logic [15:0] cfg_out;
  logic        flag_adc, busy, done, wr_full;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  int flag_cnt;
  logic [7:0] bv;

  always #5 clk = ~clk;

  pattern_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .bank_sel   (bank_sel),
    .seq_len    (seq_len),
    .repeat_cnt (repeat_cnt),
    .gate_start (gate_start),
    .flag_step  (flag_step),
    .wr_en      (wr_en),
    .wr_stb     (wr_stb),
    .wr_bank    (wr_bank),
    .wr_data    (wr_data),
    .cfg_out    (cfg_out),
    .flag_adc   (flag_adc),
    .busy       (busy),
    .done       (done),
    .wr_full    (wr_full)
  );

  // Expected word i of the ramp pattern: {i, ~i}.
  function automatic logic [15:0] ramp_word(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, ~b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    wr_data = b;
    wr_stb  = 1'b1;
    tick();
    wr_stb  = 1'b0;
  endtask

  // Drives start for one cycle; returns in cycle 1 of the run.
  task automatic start_run(input logic [1:0] b, input logic [5:0] len, input logic [7:0] rep,
                           input logic [5:0] gate, input logic [5:0] fstep);
    bank_sel   = b;
    seq_len    = len;
    repeat_cnt = rep;
    gate_start = gate;
    flag_step  = fstep;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bank_sel = 2'd0; seq_len = 6'd0;
    repeat_cnt = 8'd0; gate_start = 6'd0; flag_step = 6'd0;
    wr_en = 1'b0; wr_stb = 1'b0; wr_bank = 2'd0; wr_data = 8'd0;

    // Reset values
    tick();
    chk("rst_cfg", cfg_out, IDLE_W);
    chk("rst_flag", flag_adc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_full", wr_full, 1'b0);
    rst = 1'b0;
    tick();

    // Program bank 2 with the ramp, plus one extra strobe past full
    wr_bank = 2'd2;
    wr_en   = 1'b1;
    tick();
    chk("prog_cfg_idle", cfg_out, IDLE_W);
    for (int i = 0; i < 64; i++) begin
      bv = 8'(i);
      strobe(bv);
      if (i == 63) chk("full_before_last", wr_full, 1'b0);
      strobe(~bv);
    end
    chk("full_after_128", wr_full, 1'b1);
    strobe(8'hAA);
    chk("full_after_129", wr_full, 1'b1);
    chk("prog_cfg_idle2", cfg_out, IDLE_W);
    wr_en = 1'b0;
    tick();
    chk("full_cleared", wr_full, 1'b0);

    // Full 64-step single pass
    start_run(2'd2, 6'd63, 8'd0, 6'd0, 6'd10);
    chk("r1_busy_c1", busy, 1'b1);
    chk("r1_cfg_c1", cfg_out, IDLE_W);
    busy_cnt = 1;
    for (int k = 0; k < 64; k++) begin
      tick();
      chk("r1_word", cfg_out, ramp_word(k));
      chk("r1_flag", flag_adc, (k == 10) ? 1'b1 : 1'b0);
      chk("r1_nodone", done, 1'b0);
      if (busy) busy_cnt++;
    end
    tick();
    chk("r1_done", done, 1'b1);
    chk("r1_cfg_end", cfg_out, IDLE_W);
    chk("r1_busy_end", busy, 1'b0);
    tick();
    chk("r1_done_pulse", done, 1'b0);
    chk("r1_busy_cycles", busy_cnt, 64);

    // Repeat: 4 steps x 3 passes, flag on step 1
    start_run(2'd2, 6'd3, 8'd2, 6'd0, 6'd1);
    flag_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("r2_word", cfg_out, ramp_word(j % 4));
      chk("r2_flag", flag_adc, ((j % 4) == 1) ? 1'b1 : 1'b0);
      if (flag_adc) flag_cnt++;
    end
    tick();
    chk("r2_done", done, 1'b1);
    chk("r2_cfg_end", cfg_out, IDLE_W);
    chk("r2_flag_cnt", flag_cnt, 3);

    // Bank 1 words 0..7 = 0xFFFF
    wr_bank = 2'd1;
    wr_en   = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) strobe(8'hFF);
    wr_en = 1'b0;
    tick();

    // Gate start 5, flag step beyond sequence
    start_run(2'd1, 6'd7, 8'd0, 6'd5, 6'd63);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("r3_gated", cfg_out, (k < 5) ? 16'h7FFF : 16'hFFFF);
      chk("r3_noflag", flag_adc, 1'b0);
    end
    tick();
    chk("r3_done", done, 1'b1);

    // One-word sequence, no gating
    start_run(2'd1, 6'd0, 8'd0, 6'd0, 6'd0);
    tick();
    chk("r4_word", cfg_out, 16'hFFFF);
    chk("r4_flag", flag_adc, 1'b1);
    tick();
    chk("r4_done", done, 1'b1);
    chk("r4_cfg_end", cfg_out, IDLE_W);

    // Abort in cycle 10
    start_run(2'd2, 6'd63, 8'd0, 6'd0, 6'd9);
    repeat (9) tick();
    chk("ab_c10_word", cfg_out, ramp_word(8));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_c11_word", cfg_out, ramp_word(9));
    chk("ab_c11_flag", flag_adc, 1'b0);
    chk("ab_c11_busy", busy, 1'b0);
    tick();
    chk("ab_c12_idle", cfg_out, IDLE_W);
    for (int i = 0; i < 3; i++) begin
      chk("ab_nodone", done, 1'b0);
      tick();
    end

    // Replay from step 0; start and wr_en ignored while running
    start_run(2'd2, 6'd63, 8'd0, 6'd0, 6'd9);
    start = 1'b1;
    wr_en = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("rp_word0", cfg_out, ramp_word(0));
    chk("rp_busy", busy, 1'b1);
    tick();
    chk("rp_word1", cfg_out, ramp_word(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("rp_idle", cfg_out, IDLE_W);

    // Session with a trailing partial word
    wr_bank = 2'd3;
    wr_en   = 1'b1;
    tick();
    strobe(8'h12);
    strobe(8'h34);
    strobe(8'h56);
    wr_en = 1'b0;
    tick();
    start_run(2'd3, 6'd0, 8'd0, 6'd0, 6'd63);
    tick();
    chk("s2_word0", cfg_out, 16'h1234);
    tick();

    // Next session starts clean at word 0, byte 0
    wr_en = 1'b1;
    tick();
    strobe(8'h78);
    strobe(8'h9A);
    wr_en = 1'b0;
    tick();
    start_run(2'd3, 6'd0, 8'd0, 6'd0, 6'd63);
    tick();
    chk("s3_word0", cfg_out, 16'h789A);
    tick();

    // Asynchronous reset mid-run
    start_run(2'd2, 6'd63, 8'd0, 6'd0, 6'd3);
    repeat (4) tick();
    chk("mr_flag_before", flag_adc, 1'b1);
    chk("mr_word_before", cfg_out, ramp_word(3));
    #2 rst = 1'b1;
    #1;
    chk("mr_cfg", cfg_out, IDLE_W);
    chk("mr_flag", flag_adc, 1'b0);
    chk("mr_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_idle_busy", busy, 1'b0);
    chk("mr_idle_cfg", cfg_out, IDLE_W);

    // Asynchronous reset mid-PROG, then bank 2 still intact
    wr_bank = 2'd2;
    wr_en   = 1'b1;
    tick();
    strobe(8'hAB);
    #2 rst = 1'b1;
    #1;
    chk("mp_cfg", cfg_out, IDLE_W);
    chk("mp_full", wr_full, 1'b0);
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start_run(2'd2, 6'd2, 8'd0, 6'd0, 6'd63);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mp_intact", cfg_out, ramp_word(k));
    end
    tick();
    chk("mp_done", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Parametrised successor to the fixed 3-bank, 64 x 16 configuration sequencer.
- Plays a programmable word sequence from one of NBANK pattern banks onto cfg_out, which drives the front-end configuration bus.
- Adds programmable sequence length, repeat count, gate threshold and ADC flag step.
- Adds abort, done and busy signalling, and a byte-wide write port that runs on clk and fills any bank.

Parameters:
- WORD_W, 16: output word width; multiple of 8; BYTES = WORD_W/8.
- ADDR_W, 6: step address width; DEPTH = 2**ADDR_W words per bank.
- NBANK, 4: number of pattern banks.
- BANK_W, 2: bank select width; 2**BANK_W >= NBANK.
- IDLE_WORD, 16'h1404: value of cfg_out when not running.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a run (honoured in IDLE only).
- abort  in  1  stops a run.
- bank_sel  in  BANK_W  bank to play; latched at start.
- seq_len  in  ADDR_W  index of last step; latched at start.
- repeat_cnt  in  8  extra passes (0 = play once); latched at start.
- gate_start  in  ADDR_W  MSB of cfg_out is forced 0 for steps < gate_start; latched.
- flag_step  in  ADDR_W  step that raises flag_adc; latched.
- wr_en  in  1  programming mode request.
- wr_stb  in  1  1-cycle byte strobe, clk domain.
- wr_bank  in  BANK_W  bank to program; latched on PROG entry.
- wr_data  in  8  byte to write, MSB byte first.
- cfg_out  out  WORD_W  registered configuration word.
- flag_adc  out  1  registered 1-cycle pulse.
- busy  out  1  high in RUN.
- done  out  1  1-cycle pulse at normal completion.
- wr_full  out  1  high once DEPTH words have been written in the current PROG session.

Behaviour:
- Reset (async, any state): state = IDLE; step, pass, wptr and byte counters = 0; cfg_out = IDLE_WORD; flag_adc, busy, done, wr_full = 0. Bank memory contents are not reset.
- State IDLE:
  - cfg_out = IDLE_WORD.
  - wr_en=1 -> PROG (takes priority over start).
  - Otherwise start=1 -> RUN; latch the config inputs; step = 0; pass = 0.
- State RUN, each cycle:
  - cfg_out <= mem[bank][step], with bit WORD_W-1 ANDed with (step >= gate_start).
  - flag_adc <= (step == flag_step) on every pass.
  - busy = 1.
- Timing: start sampled in cycle 0; the step-k word is visible on cfg_out in cycle k+2. Total words emitted = (seq_len+1)*(repeat_cnt+1), back to back with no gap between passes.
- End of pass (step == seq_len):
  - pass < repeat_cnt -> step = 0; pass++.
  - Otherwise -> IDLE; done pulses the next cycle; cfg_out returns to IDLE_WORD the cycle after the last word.
- seq_len = 0 is a one-word sequence.
- flag_step > seq_len: flag_adc never fires.
- gate_start = 0: no gating.
- In RUN, start and wr_en are ignored.
- abort=1 in RUN -> IDLE next edge; no done pulse; cfg_out = IDLE_WORD from the next cycle; flag_adc cleared. abort has priority over end-of-pass.
- State PROG:
  - Each wr_stb shifts wr_data into the word assembler, MSB byte first.
  - On the BYTES-th byte: mem[wr_bank][wptr] <= assembled word, wptr++. The newly completed word is written, not the previous word.
  - After DEPTH words: wr_full = 1; further strobes are ignored, with no wrap.
  - wr_en=0 -> IDLE; wptr, byte counter and wr_full cleared; any partial word is discarded.
  - cfg_out holds IDLE_WORD throughout PROG.
  - A memory written in PROG is readable in the first RUN after it.
- Banks are inferred synchronous RAM or registers: NBANK x DEPTH x WORD_W, one write port, one read port.

Test Plan:
- Program bank 2 via 2*64 strobes with word i = {i, ~i}; start with bank_sel=2, seq_len=63, repeat_cnt=0, gate_start=0 -> cfg_out steps through 0x00FF, 0x01FE, ... in cycles 2..65; done in cycle 66; busy high for 64 cycles.
- seq_len=3, repeat_cnt=2, flag_step=1 -> 12 words emitted with no gaps; flag_adc pulses 3 times at the step-1 slots.
- gate_start=5, all words 0xFFFF -> cfg_out = 0x7FFF for steps 0-4, then 0xFFFF.
- abort in cycle 10 of a 64-step run -> cfg_out = IDLE_WORD from cycle 12; done never pulses; a later start replays from step 0.
- PROG with 129 strobes -> wr_full after the 128th; the 129th byte leaves word 63 unchanged. Second session: 3 strobes then drop wr_en -> word 0 = first two bytes; the third byte is discarded.
- Assert rst mid-run and mid-PROG -> outputs take reset values immediately (async); state IDLE; earlier bank contents intact.
